ic4164_ram: RTL and testbench



---
 rtl/ic4164_pkg.sv | 22 ++
 rtl/ic4164_array.sv | 21 ++
 rtl/ic4164_ram.sv | 140 ++++++++++++++
 tb/tb_ic4164_ram.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ic4164_pkg.sv
// Shared widths, depth and access-state encoding for the 4164 DRAM model.
package ic4164_pkg;

  localparam int unsigned ROW_W  = 8;
  localparam int unsigned COL_W  = 8;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DEPTH  = 65536;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_WAIT,
    ACC_DRIVE,
    ACC_WRITE
  } acc_state_t;

  typedef struct packed {
    logic nwe;
    logic nras;
    logic ncas;
  } strobes_t;

endpackage

// File: rtl/ic4164_array.sv
// 64K x 1 storage: synchronous write, combinational read, zero at time zero.
module ic4164_array
  import ic4164_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic              wd,
  input  logic [ADDR_W-1:0] raddr,
  output logic              rd
);

  logic mem [DEPTH] = '{default: 1'b0};

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wd;
  end

  assign rd = mem[raddr];

endmodule

// File: rtl/ic4164_ram.sv
// 4164-style 64K x 1 DRAM: synchronized RAS/CAS/WE strobes, early/late write,
// page mode, read data held until CAS rises.
module ic4164_ram
  import ic4164_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic             nwe,
  input  logic             nras,
  input  logic             ncas,
  input  logic             di,
  input  logic [ROW_W-1:0] l,
  output logic             dout,
  input  logic             clk,
  input  logic             rst_n
);

  localparam int unsigned CNT_W = (ACCESS_CYCLES < 2) ? 1 : $clog2(ACCESS_CYCLES);

  strobes_t         strb_pipe [SYNC_STAGES];
  logic [ROW_W:0]   data_pipe [SYNC_STAGES];
  strobes_t         strb_sync;
  strobes_t         strb_prev;
  logic [ROW_W-1:0] l_d;
  logic             di_d;

  // Address/data ride a pipeline of equal depth so they line up with the
  // synchronized strobe edge that captures them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        strb_pipe[i] <= '1;
        data_pipe[i] <= '0;
      end
      strb_prev <= '1;
    end else begin
      strb_pipe[0] <= {nwe, nras, ncas};
      data_pipe[0] <= {l, di};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        strb_pipe[i] <= strb_pipe[i-1];
        data_pipe[i] <= data_pipe[i-1];
      end
      strb_prev <= strb_sync;
    end
  end

  assign strb_sync   = strb_pipe[SYNC_STAGES-1];
  assign {l_d, di_d} = data_pipe[SYNC_STAGES-1];

  logic ras_fall, cas_fall, cas_rise, we_fall;
  assign ras_fall = strb_prev.nras & ~strb_sync.nras;
  assign cas_fall = strb_prev.ncas & ~strb_sync.ncas;
  assign cas_rise = ~strb_prev.ncas & strb_sync.ncas;
  assign we_fall  = strb_prev.nwe & ~strb_sync.nwe;

  acc_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [ROW_W-1:0] row, row_n;
  logic [COL_W-1:0] col, col_n;
  logic             rd_data, rd_data_n;
  logic             mem_we, mem_wd, mem_rd;
  logic [ADDR_W-1:0] mem_waddr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ACC_IDLE;
      cnt     <= '0;
      row     <= '0;
      col     <= '0;
      rd_data <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      row     <= row_n;
      col     <= col_n;
      rd_data <= rd_data_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    row_n     = ras_fall ? l_d : row;
    col_n     = col;
    rd_data_n = rd_data;
    mem_we    = 1'b0;
    mem_waddr = {col, row};
    mem_wd    = di_d;
    case (state)
      ACC_IDLE: begin
        if (cas_fall && !strb_sync.nras) begin
          col_n = l_d;
          if (!strb_sync.nwe) begin
            mem_we    = 1'b1;
            mem_waddr = {l_d, row_n};
            state_n   = ACC_WRITE;
          end else begin
            cnt_n   = CNT_W'(ACCESS_CYCLES - 1);
            state_n = ACC_WAIT;
          end
        end
      end
      ACC_WAIT: begin
        if (cas_rise) begin
          state_n = ACC_IDLE;
        end else begin
          mem_we = we_fall;
          if (cnt == '0) begin
            rd_data_n = mem_rd;
            state_n   = ACC_DRIVE;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
      end
      ACC_DRIVE: begin
        // Output stays on the latched value even if a late write changes the cell.
        if (cas_rise) state_n = ACC_IDLE;
        else          mem_we  = we_fall;
      end
      ACC_WRITE: begin
        if (cas_rise) state_n = ACC_IDLE;
      end
      default: state_n = ACC_IDLE;
    endcase
  end

  ic4164_array u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wd    (mem_wd),
    .raddr ({col, row}),
    .rd    (mem_rd)
  );

  assign dout = (state == ACC_DRIVE) ? rd_data : 1'bz;

endmodule

// File: tb/tb_ic4164_ram.sv
// Bench for ic4164_ram: two identical instances, one output pulled up and one
// pulled down, so a released output is distinguishable from a driven level.
module tb_ic4164_ram;

  localparam int unsigned SYNC = 2;
  localparam int unsigned ACC  = 2;
  localparam int          G    = SYNC + 2;
  localparam int          ZV   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       nwe = 1'b1, nras = 1'b1, ncas = 1'b1, di = 1'b0;
  logic [7:0] l = '0;
  wire        dout_pu, dout_pd;

  pullup   (dout_pu);
  pulldown (dout_pd);

  ic4164_ram #(.SYNC_STAGES(SYNC), .ACCESS_CYCLES(ACC)) dut_pu (
    .nwe(nwe), .nras(nras), .ncas(ncas), .di(di), .l(l), .dout(dout_pu),
    .clk(clk), .rst_n(rst_n)
  );
  ic4164_ram #(.SYNC_STAGES(SYNC), .ACCESS_CYCLES(ACC)) dut_pd (
    .nwe(nwe), .nras(nras), .ncas(ncas), .di(di), .l(l), .dout(dout_pd),
    .clk(clk), .rst_n(rst_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit model [65536];

  typedef struct {
    bit         is_write;
    logic [7:0] row;
    logic [7:0] col;
    bit         d;
    int         exp;
  } vec_t;
  vec_t vecs [10];

  // 0/1 driven, 2 released, 3 contention or unknown
  function automatic int obs();
    if (dout_pu === dout_pd && (dout_pu === 1'b0 || dout_pu === 1'b1)) return int'(dout_pu);
    if (dout_pu === 1'b1 && dout_pd === 1'b0) return ZV;
    return 3;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (2=Z)", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_access(input logic [7:0] row, input logic [7:0] col);
    l = row; step(1); nras = 1'b0; step(G);
    l = col; step(1); ncas = 1'b0; step(SYNC + ACC + 1);
  endtask

  task automatic do_write(input logic [7:0] row, input logic [7:0] col, input bit d,
                          input string name);
    int got;
    l = row; step(1); nras = 1'b0; step(G);
    nwe = 1'b0; di = d; l = col; step(1); ncas = 1'b0;
    got = ZV;
    repeat (SYNC + ACC + 3) begin
      step(1);
      if (obs() != ZV && got == ZV) got = obs();
    end
    chk(name, got, ZV);
    nwe = 1'b1; di = 1'b0; step(1); ncas = 1'b1; step(G); nras = 1'b1; step(G);
    model[{col, row}] = d;
  endtask

  task automatic do_read(input logic [7:0] row, input logic [7:0] col, input int exp,
                         input string name);
    l = row; step(1); nras = 1'b0; step(G);
    l = col; step(1); ncas = 1'b0;
    step(SYNC + ACC - 1); chk({name, "_lat"}, obs(), ZV);
    step(2);              chk(name, obs(), exp);
    ncas = 1'b1; step(SYNC + 1); chk({name, "_rel"}, obs(), ZV);
    nras = 1'b1; step(G);
  endtask

  task automatic do_rmw(input logic [7:0] row, input logic [7:0] col, input bit d,
                        input int exp_old, input string name);
    start_access(row, col);
    chk({name, "_old"}, obs(), exp_old);
    di = d; nwe = 1'b0; step(G);
    chk({name, "_hold"}, obs(), exp_old);
    nwe = 1'b1; ncas = 1'b1; step(G); nras = 1'b1; step(G);
    model[{col, row}] = d;
  endtask

  initial begin
    logic [15:0] pool [6];
    logic [15:0] a;
    int          op;
    bit          d;

    vecs[0] = '{1'b1, 8'hFF, 8'hFF, 1'b1, ZV};
    vecs[1] = '{1'b1, 8'h00, 8'h00, 1'b1, ZV};
    vecs[2] = '{1'b1, 8'hFF, 8'h00, 1'b0, ZV};
    vecs[3] = '{1'b0, 8'hFF, 8'hFF, 1'b0, 1};
    vecs[4] = '{1'b0, 8'h00, 8'h00, 1'b0, 1};
    vecs[5] = '{1'b0, 8'h00, 8'hFF, 1'b0, 0};
    vecs[6] = '{1'b0, 8'hFF, 8'h00, 1'b0, 0};
    vecs[7] = '{1'b1, 8'h01, 8'h00, 1'b1, ZV};
    vecs[8] = '{1'b0, 8'h01, 8'h00, 1'b0, 1};
    vecs[9] = '{1'b0, 8'h00, 8'h01, 1'b0, 0};

    step(3);
    chk("reset_z", obs(), ZV);
    rst_n = 1'b1; step(2);
    chk("post_reset_z", obs(), ZV);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_write) do_write(vecs[i].row, vecs[i].col, vecs[i].d, $sformatf("vec%0d_wr", i));
      else                  do_read(vecs[i].row, vecs[i].col, vecs[i].exp, $sformatf("vec%0d_rd", i));
    end

    do_write(8'hA2, 8'hA4, 1'b1, "early_wr_a4a2_z");
    do_read(8'hA2, 8'hA4, 1, "rd_a4a2");

    start_access(8'hA2, 8'hA4);
    chk("release_pre", obs(), 1);
    nras = 1'b1; step(G + 2);
    chk("ras_release_hold", obs(), 1);
    ncas = 1'b1; step(SYNC + 1);
    chk("cas_release_z", obs(), ZV);
    step(G);

    do_rmw(8'h01, 8'h00, 1'b0, 1, "rmw_0001");
    do_read(8'h01, 8'h00, 0, "rmw_0001_after");

    l = 8'h33; ncas = 1'b0; step(G);
    nwe = 1'b0; di = 1'b1; step(1); nras = 1'b0; step(G + ACC + 2);
    chk("cbr_z", obs(), ZV);
    nras = 1'b1; ncas = 1'b1; nwe = 1'b1; di = 1'b0; step(G);
    do_read(8'h33, 8'h33, 0, "cbr_no_write");

    l = 8'hA2; step(1); nras = 1'b0; step(G); nras = 1'b1; step(G);

    l = 8'hA2; step(1); nras = 1'b0; step(G);
    l = 8'hA4; step(1); ncas = 1'b0; step(SYNC + ACC + 1);
    chk("page_rd_a4", obs(), int'(model[16'hA4A2]));
    ncas = 1'b1; step(G);
    l = 8'h10; nwe = 1'b0; di = 1'b1; step(1); ncas = 1'b0; step(SYNC + ACC + 1);
    chk("page_wr_z", obs(), ZV);
    nwe = 1'b1; ncas = 1'b1; step(G);
    model[16'h10A2] = 1'b1;
    l = 8'h10; step(1); ncas = 1'b0; step(SYNC + ACC + 1);
    chk("page_rd_10", obs(), int'(model[16'h10A2]));
    ncas = 1'b1; step(G); nras = 1'b1; step(G);

    start_access(8'hA2, 8'hA4);
    chk("rst_pre", obs(), 1);
    rst_n = 1'b0; #1;
    chk("rst_abort_z", obs(), ZV);
    ncas = 1'b1; nras = 1'b1; step(2); rst_n = 1'b1; step(G);
    do_read(8'hA2, 8'hA4, 1, "rd_after_reset");

    start_access(8'h55, 8'h55);
    chk("rst_wr_pre", obs(), 0);
    di = 1'b1; nwe = 1'b0; #1;
    rst_n = 1'b0; step(1);
    nwe = 1'b1; ncas = 1'b1; nras = 1'b1; di = 1'b0; step(2); rst_n = 1'b1; step(G);
    do_read(8'h55, 8'h55, int'(model[16'h5555]), "rst_wr_discard");

    for (int i = 0; i < 6; i++) pool[i] = 16'($urandom);
    for (int k = 0; k < 60; k++) begin
      a  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : pool[$urandom_range(0, 5)];
      op = int'($urandom_range(0, 2));
      d  = 1'($urandom_range(0, 1));
      case (op)
        0:       do_write(a[7:0], a[15:8], d, $sformatf("rnd%0d_wr", k));
        1:       do_read(a[7:0], a[15:8], int'(model[a]), $sformatf("rnd%0d_rd", k));
        default: do_rmw(a[7:0], a[15:8], d, int'(model[a]), $sformatf("rnd%0d_rmw", k));
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
